// File: rtl/mxu_skew_stage.sv
`default_nettype none
// ============================================================================
// Module   : mxu_skew_stage
// Brief    : Per-lane triangular delay chains (skew or deskew) with valid bits,
//            ready/valid stall, synchronous flush and drain-done detection.
// Revision : 1.0
// ============================================================================
module mxu_skew_stage #(
  parameter int LANES      = 3,
  parameter int LANE_WIDTH = 4,
  parameter int DESKEW     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        test_mode,
  input  logic                        flush,
  input  logic [LANES*LANE_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*LANE_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_lane_valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        drain_done
);

  logic             advance;
  logic             accept;
  logic [LANES-1:0] lane_busy;
  logic [LANES-1:0] lane_next;

  assign advance  = enable & out_ready & ~test_mode & ~flush;
  assign in_ready = test_mode ? out_ready : advance;
  assign accept   = in_valid & advance;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int DLY = (DESKEW != 0) ? (LANES - 1 - l) : l;
    localparam int LSB = LANE_WIDTH * (LANES - 1 - l);

    logic [LANE_WIDTH-1:0] lane_in;
    assign lane_in = in_data[LSB +: LANE_WIDTH];

    if (DLY == 0) begin : g_pass
      assign out_data[LSB +: LANE_WIDTH] = lane_in;
      assign out_lane_valid[l]           = test_mode ? in_valid : accept;
      assign lane_busy[l]                = 1'b0;
      assign lane_next[l]                = 1'b0;
    end else begin : g_chain
      logic [DLY-1:0][LANE_WIDTH-1:0] data_q;
      logic [DLY-1:0]                 vld_q;
      logic                           nxt_any;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
          vld_q  <= '0;
        end else if (flush) begin
          data_q <= '0;
          vld_q  <= '0;
        end else if (advance) begin
          for (int i = DLY - 1; i > 0; i--) begin
            data_q[i] <= data_q[i-1];
            vld_q[i]  <= vld_q[i-1];
          end
          // Idle input cycles enter the chain as zero-data bubbles.
          data_q[0] <= in_valid ? lane_in : '0;
          vld_q[0]  <= in_valid;
        end
      end

      // Valid occupancy of this chain after a shift (only consulted on advance).
      always_comb begin
        nxt_any = in_valid;
        for (int i = 0; i < DLY - 1; i++) begin
          nxt_any = nxt_any | vld_q[i];
        end
      end

      assign out_data[LSB +: LANE_WIDTH] = test_mode ? lane_in : data_q[DLY-1];
      assign out_lane_valid[l]           = test_mode ? in_valid : vld_q[DLY-1];
      assign lane_busy[l]                = |vld_q;
      assign lane_next[l]                = nxt_any;
    end
  end

  assign out_valid = |out_lane_valid;
  assign busy      = |lane_busy;

  if (LANES == 1) begin : g_no_drain
    assign drain_done = 1'b0;
  end else begin : g_drain
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        drain_done <= 1'b0;
      end else begin
        drain_done <= advance & busy & ~(|lane_next);
      end
    end
  end

endmodule
`default_nettype wire
